// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: data width, reset PC and queue entry type.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] adr);
    return {adr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop/flush and an occupancy output.
// Storage is registered and read combinationally from the head slot, so a
// word pushed in one cycle is visible at the output from the next cycle on.
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Pushes into a full FIFO and pops from an empty one are ignored.
  assign do_push_s = push_i & (count_q != FULL);
  assign do_pop_s  = pop_i & (count_q != '0);

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push_s) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + AW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (do_pop_s) begin
        rptr_d = rptr_q + AW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory, queues returned words with their PC and hands the queue head to
// decode. A redirect flushes the queue and discards in-flight responses.
// Optional feature macro: FETCH_MISALIGN_EN (flag misaligned redirect targets
// on misaligned_o and halt fetch until the next redirect).
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int              FIFO_DEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = PC_RESET
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_adr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            branch_v_i,
  input  logic [XLEN-1:0] branch_adr_i,
  output logic            instr_v_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i
`ifdef FETCH_MISALIGN_EN
  ,
  output logic            misaligned_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   kill_q, kill_d;
  logic [CW-1:0]   count_s;
  logic [CW-1:0]   pend_s;
  logic [CW:0]     occ_s;
  logic [XLEN-1:0] req_pc_s;
  logic            req_s, grant_s, push_s, pop_s, halt_s;
  fetch_entry_t    wr_entry_s, head_s;

  // Queued words plus outstanding requests never exceed the queue depth,
  // so every response that is kept always finds a free slot.
  assign occ_s   = {1'b0, count_s} + {1'b0, pend_s};
  assign req_s   = reset_n & (occ_s < DEPTH_W) & ~branch_v_i & ~halt_s;
  assign grant_s = req_s & imem_gnt_i;
  assign push_s  = imem_rvalid_i & ~branch_v_i & (kill_q == '0);
  assign pop_s   = instr_v_o & instr_ready_i & ~branch_v_i;

  // Pair the returning word with the PC recorded when it was granted.
  always_comb begin
    wr_entry_s.instr = imem_rdata_i;
    wr_entry_s.pc    = req_pc_s;
  end

  // PC of every granted request; popped by each response, kept or dropped.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN)
  ) u_pc_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (1'b0),
    .push_i  (grant_s),
    .pop_i   (imem_rvalid_i),
    .wdata_i (pc_q),
    .rdata_o (req_pc_s),
    .count_o (pend_s)
  );

  // Instruction queue presented to decode.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_instr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (branch_v_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wr_entry_s),
    .rdata_o (head_s),
    .count_o (count_s)
  );

  // Next fetch address and count of stale responses still to be discarded.
  always_comb begin
    pc_d   = pc_q;
    kill_d = kill_q;
    if (branch_v_i) begin
      pc_d   = align_word(branch_adr_i);
      kill_d = imem_rvalid_i ? (pend_s - CW'(1)) : pend_s;
    end else begin
      if (grant_s) begin
        pc_d = pc_q + XLEN'(4);
      end else begin
        pc_d = pc_q;
      end
      if (imem_rvalid_i && (kill_q != '0)) begin
        kill_d = kill_q - CW'(1);
      end else begin
        kill_d = kill_q;
      end
    end
  end

  // PC and kill counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q   <= RESET_VECTOR;
      kill_q <= '0;
    end else begin
      pc_q   <= pc_d;
      kill_q <= kill_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  logic halt_q, halt_d;
  logic mis_q, mis_d;

  // A misaligned redirect target raises a one-cycle flag and parks fetch
  // until a later redirect supplies an aligned target.
  always_comb begin
    mis_d = branch_v_i & (branch_adr_i[1:0] != 2'b00);
    if (branch_v_i) begin
      halt_d = mis_d;
    end else begin
      halt_d = halt_q;
    end
  end

  // Misalignment flag and halt registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      halt_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      halt_q <= halt_d;
      mis_q  <= mis_d;
    end
  end

  assign halt_s       = halt_q;
  assign misaligned_o = mis_q;
`else
  assign halt_s = 1'b0;
`endif

  assign imem_req_o = req_s;
  assign imem_adr_o = pc_q;
  assign instr_v_o  = (count_s != '0);
  assign instr_o    = head_s.instr;
  assign pc_o       = head_s.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: the bench acts as the instruction
// memory (in-order responses with random delay) and checks the decode-side
// stream against the expected sequential PC flow after reset and redirects.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam int D = 2;
  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        reset_n;
  logic        imem_req_o;
  logic [31:0] imem_adr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        branch_v_i;
  logic [31:0] branch_adr_i;
  logic        instr_v_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
`ifdef FETCH_MISALIGN_EN
  logic        misaligned_o;
`endif

  instr_fetch #(.FIFO_DEPTH(D), .RESET_VECTOR(RV)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req_o    (imem_req_o),
    .imem_adr_o    (imem_adr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .branch_v_i    (branch_v_i),
    .branch_adr_i  (branch_adr_i),
    .instr_v_o     (instr_v_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
`ifdef FETCH_MISALIGN_EN
    ,
    .misaligned_o  (misaligned_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          nerr = 0;
  int          nchk = 0;
  int          cyc;
  int          grants, pops, first_v_cyc, last_br_cyc, first_v_after_br;
  bit          use_const, halted;
  logic [31:0] exp_pc, exp_fetch;
  bit          p_br, p_req, p_gnt, p_v, p_pop;
  logic [31:0] p_badr, p_adr, p_pc, p_instr;

  function automatic logic [31:0] word(input logic [31:0] adr);
    if (use_const) return 32'h0050_0093;
    return (adr * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic release_reset();
    mq.delete();
    exp_pc = RV; exp_fetch = RV; halted = 1'b0;
    p_br = 1'b0; p_req = 1'b0; p_gnt = 1'b0; p_v = 1'b0; p_pop = 1'b0;
    p_badr = 32'h0; p_adr = 32'h0; p_pc = 32'h0; p_instr = 32'h0;
    grants = 0; pops = 0; first_v_cyc = -1; last_br_cyc = -1; first_v_after_br = -1;
    reset_n = 1'b1;
    cyc = 1;
  endtask

  task automatic idle_inputs();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    branch_v_i = 1'b0; branch_adr_i = 32'h0; instr_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    release_reset();
  endtask

  // One clock cycle: drive inputs, act as memory, check outputs, update model.
  task automatic step(input bit gnt, input bit rdy, input bit br,
                      input logic [31:0] badr, input int dmin, input int dmax);
    bit exp_mis;
    imem_gnt_i = gnt; instr_ready_i = rdy; branch_v_i = br; branch_adr_i = badr;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1; imem_rdata_i = word(mq[0].adr);
    end else begin
      imem_rvalid_i = 1'b0; imem_rdata_i = $urandom;
    end
    @(negedge clk);
    if (br) begin
      nchk++;
      if (imem_req_o !== 1'b0) begin
        nerr++; $display("FAIL redirect_noreq cyc=%0d: req=%b want 0", cyc, imem_req_o);
      end
    end
    if (p_req && !p_gnt && !p_br && !br) begin
      nchk++;
      if (imem_req_o !== 1'b1 || imem_adr_o !== p_adr) begin
        nerr++; $display("FAIL req_hold cyc=%0d: req=%b adr=%h want 1 %h", cyc, imem_req_o, imem_adr_o, p_adr);
      end
    end
    if (halted && !br) begin
      nchk++;
      if (imem_req_o !== 1'b0) begin
        nerr++; $display("FAIL halt_noreq cyc=%0d: req=%b want 0", cyc, imem_req_o);
      end
    end
    if (p_br) begin
      nchk++;
      if (instr_v_o !== 1'b0) begin
        nerr++; $display("FAIL flush_v cyc=%0d: instr_v=%b want 0", cyc, instr_v_o);
      end
    end
    if (p_v && !p_pop && !p_br) begin
      nchk++;
      if (instr_v_o !== 1'b1 || pc_o !== p_pc || instr_o !== p_instr) begin
        nerr++; $display("FAIL head_hold cyc=%0d: v=%b pc=%h instr=%h want 1 %h %h", cyc, instr_v_o, pc_o, instr_o, p_pc, p_instr);
      end
    end
`ifdef FETCH_MISALIGN_EN
    exp_mis = p_br && (p_badr[1:0] != 2'b00);
    nchk++;
    if (misaligned_o !== exp_mis) begin
      nerr++; $display("FAIL misaligned cyc=%0d: got %b want %b", cyc, misaligned_o, exp_mis);
    end
`else
    exp_mis = 1'b0;
`endif
    if (imem_rvalid_i) void'(mq.pop_front());
    if (imem_req_o === 1'b1 && gnt) begin
      nchk++;
      if (imem_adr_o !== exp_fetch) begin
        nerr++; $display("FAIL fetch_adr cyc=%0d: adr=%h want %h", cyc, imem_adr_o, exp_fetch);
      end
      mq.push_back('{adr: imem_adr_o, due: cyc + 1 + int'($urandom_range(dmax, dmin))});
      exp_fetch = exp_fetch + 32'd4;
      grants++;
    end
    nchk++;
    if (mq.size() > D) begin
      nerr++; $display("FAIL outstanding cyc=%0d: got %0d want <= %0d", cyc, mq.size(), D);
    end
    if (instr_v_o === 1'b1 && first_v_cyc < 0) first_v_cyc = cyc;
    if (instr_v_o === 1'b1 && last_br_cyc >= 0 && first_v_after_br < 0 && cyc > last_br_cyc)
      first_v_after_br = cyc;
    if (instr_v_o === 1'b1 && rdy && !br) begin
      nchk++;
      if (pc_o !== exp_pc || instr_o !== word(exp_pc)) begin
        nerr++; $display("FAIL pop_data cyc=%0d: pc=%h instr=%h want %h %h", cyc, pc_o, instr_o, exp_pc, word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (br) begin
      exp_pc = {badr[31:2], 2'b00};
      exp_fetch = {badr[31:2], 2'b00};
      last_br_cyc = cyc;
      first_v_after_br = -1;
`ifdef FETCH_MISALIGN_EN
      halted = (badr[1:0] != 2'b00);
`endif
    end
    p_br = br; p_badr = badr; p_req = imem_req_o; p_gnt = gnt; p_adr = imem_adr_o;
    p_v = instr_v_o; p_pop = instr_v_o && rdy; p_pc = pc_o; p_instr = instr_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nchk++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    nchk++; if (instr_v_o !== 1'b0) begin nerr++; $display("FAIL reset_v: got %b want 0", instr_v_o); end
    nchk++; if (imem_adr_o !== RV) begin nerr++; $display("FAIL reset_adr: got %h want %h", imem_adr_o, RV); end
    nchk++; if (pc_o !== 32'h0) begin nerr++; $display("FAIL reset_pc: got %h want 0", pc_o); end
    nchk++; if (instr_o !== 32'h0) begin nerr++; $display("FAIL reset_instr: got %h want 0", instr_o); end
`ifdef FETCH_MISALIGN_EN
    nchk++; if (misaligned_o !== 1'b0) begin nerr++; $display("FAIL reset_mis: got %b want 0", misaligned_o); end
`endif
    @(posedge clk);
    #1;
    release_reset();
  endtask

  task automatic test_first_fetch();
    use_const = 1'b1;
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    nchk++; if (first_v_cyc != 3) begin nerr++; $display("FAIL first_valid_cycle: got %0d want 3", first_v_cyc); end
    nchk++; if (pops < 3) begin nerr++; $display("FAIL first_fetch_pops: got %0d want >= 3", pops); end
    use_const = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    nchk++; if (grants != 2) begin nerr++; $display("FAIL bp_grants: got %0d want 2", grants); end
    nchk++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL bp_req: got %b want 0", imem_req_o); end
    nchk++;
    if (instr_v_o !== 1'b1 || pc_o !== RV || instr_o !== word(RV)) begin
      nerr++; $display("FAIL bp_head: v=%b pc=%h instr=%h want 1 %h %h", instr_v_o, pc_o, instr_o, RV, word(RV));
    end
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_redirect_pending();
    int  pops0;
    bit  found;
    do_reset();
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mq.size() == D) begin found = 1'b1; break; end
      step(1'b1, 1'b1, 1'b0, 32'h0, 4, 4);
    end
    nchk++; if (!found) begin nerr++; $display("FAIL pending_setup: got %0d pending want %0d", mq.size(), D); end
    pops0 = pops;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 0, 0);
    repeat (15) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    nchk++; if (pops <= pops0 + 2) begin nerr++; $display("FAIL redirect_resume: got %0d pops want > %0d", pops - pops0, 2); end
  endtask

  task automatic test_redirect_same_cycle();
    bit found;
    int g0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() > 0 && mq[0].due <= cyc && instr_v_o === 1'b1) begin found = 1'b1; break; end
      step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    end
    nchk++; if (!found) begin nerr++; $display("FAIL same_cycle_setup: no rvalid+valid cycle within bound"); end
    step(1'b1, 1'b1, 1'b1, 32'h0000_0400, 0, 0);
    g0 = grants;
    step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    nchk++; if (grants != g0 + 1) begin nerr++; $display("FAIL target_req_n1: got %0d grants want %0d", grants - g0, 1); end
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    nchk++;
    if (first_v_after_br != last_br_cyc + 3) begin
      nerr++; $display("FAIL redirect_latency: got %0d want %0d", first_v_after_br - last_br_cyc, 3);
    end
  endtask

  task automatic test_random();
    int          stall;
    int          pops0;
    bit          gnt, rdy, br;
    logic [31:0] badr;
    do_reset();
    stall = 0;
    pops0 = pops;
    for (int i = 0; i < 3000; i++) begin
      gnt = (stall == 0);
      if (stall > 0) stall--; else stall = int'($urandom_range(3, 0));
      rdy = ($urandom_range(3, 0) != 0);
      br = ($urandom_range(49, 0) == 0);
      badr = $urandom & 32'hFFFF_FFFC;
`ifndef FETCH_MISALIGN_EN
      badr = badr | 32'($urandom_range(3, 0));
`endif
      step(gnt, rdy, br, badr, 0, 3);
    end
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    nchk++; if (pops - pops0 < 500) begin nerr++; $display("FAIL random_progress: got %0d pops want >= 500", pops - pops0); end
  endtask

  task automatic test_mid_reset();
    repeat (7) step(1'b1, 1'b0, 1'b0, 32'h0, 2, 3);
    reset_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    nchk++; if (imem_req_o !== 1'b0 || instr_v_o !== 1'b0) begin
      nerr++; $display("FAIL mid_reset_outputs: req=%b v=%b want 0 0", imem_req_o, instr_v_o);
    end
    @(posedge clk);
    #1;
    release_reset();
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    nchk++; if (pops < 3) begin nerr++; $display("FAIL mid_reset_restart: got %0d pops want >= 3", pops); end
  endtask

`ifdef FETCH_MISALIGN_EN
  task automatic test_misalign();
    int g0, pops0;
    do_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0202, 0, 0);
    nchk++; if (misaligned_o !== 1'b1) begin nerr++; $display("FAIL mis_pulse: got %b want 1", misaligned_o); end
    g0 = grants;
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    nchk++; if (grants != g0) begin nerr++; $display("FAIL mis_halt: got %0d grants want 0", grants - g0); end
    pops0 = pops;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0300, 0, 0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    nchk++; if (pops <= pops0) begin nerr++; $display("FAIL mis_resume: got %0d pops want > 0", pops - pops0); end
  endtask
`endif

  initial begin
    use_const = 1'b0;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_pending();
    test_redirect_same_cycle();
`ifdef FETCH_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
